uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser.sv | 156 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Length-framed packet parser behind a first-word-fall-through UART RX FIFO.
// Frame: SOF, LEN, LEN payload bytes (forwarded immediately), 8-bit additive checksum.
module uart_frame_parser #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   MAX_LEN        = 16,
  parameter int                   TIMEOUT_CYCLES = 100000,
  parameter logic [DATA_BITS-1:0] SOF            = 8'h7E
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_empty,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_uart,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic [7:0]           drop_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CSUM} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sum_q, sum_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [7:0]           drop_q, drop_d;
  logic                 ok_q, ok_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;

  logic pop;
  logic timeout;

  // Payload bytes pass straight through; the FIFO is popped only on a downstream handshake.
  assign out_data  = rd_data;
  assign out_valid = !rst && (state_q == PAYLOAD) && !rx_empty;
  assign out_last  = !rst && (state_q == PAYLOAD) && (cnt_q == CW'(1));
  assign pop       = (state_q == PAYLOAD) ? (out_valid && out_ready) : (!rst && !rx_empty);
  assign rd_uart   = pop;
  assign timeout   = (state_q != IDLE) && rx_empty && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign drop_cnt  = drop_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    drop_d  = drop_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;

    // Timer restarts on every pop and idles at zero while hunting; a stall with data waiting holds it.
    if (state_q == IDLE || pop) begin
      timer_d = '0;
    end else if (rx_empty) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          if (rd_data == SOF) begin
            state_d = LEN;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      LEN: begin
        if (pop) begin
          if (rd_data == '0 || rd_data > DATA_BITS'(MAX_LEN)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
          end else begin
            state_d = PAYLOAD;
            cnt_d   = CW'(rd_data);
            sum_d   = rd_data;
          end
        end
      end
      PAYLOAD: begin
        if (pop) begin
          sum_d = sum_q + rd_data;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (pop) begin
          state_d = IDLE;
          if (rd_data == sum_q) begin
            ok_d   = 1'b1;
            code_d = ERR_NONE;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A timeout can only fire with the FIFO empty, so it never coincides with a deciding pop.
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      timer_q <= '0;
      drop_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      timer_q <= timer_d;
      drop_q  <= drop_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: a queue models the RX FIFO, expected beats and
// frame results are queued as bytes are pushed and compared as the DUT produces them.
module tb_uart_frame_parser;

  localparam int DW = 8;
  localparam int ML = 16;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_empty;
  logic [DW-1:0] rd_data;
  logic          rd_uart;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          frame_ok;
  logic          frame_err;
  logic [1:0]    err_code;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .DATA_BITS      (DW),
    .MAX_LEN        (ML),
    .TIMEOUT_CYCLES (TO),
    .SOF            (8'h7E)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_empty  (rx_empty),
    .rd_data   (rd_data),
    .rd_uart   (rd_uart),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .drop_cnt  (drop_cnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic       ok;
    logic [1:0] code;
  } res_t;

  logic [7:0] fifo[$];
  logic [7:0] pl[$];
  beat_t      exp_beats[$];
  res_t       exp_res[$];

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int last_pop_cyc = 0;
  bit pop_pending = 1'b0;
  bit rand_ready  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic refresh();
    rx_empty = (fifo.size() == 0);
    rd_data  = rx_empty ? '0 : fifo[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    refresh();
  endtask

  task automatic monitor();
    res_t r;
    if (out_valid) begin
      if (exp_beats.size() == 0) begin
        check("unexp_valid", 1, 0);
      end else begin
        check("out_data", out_data, exp_beats[0].data);
        check("out_last", out_last, exp_beats[0].last);
        if (out_ready) void'(exp_beats.pop_front());
      end
    end
    if (frame_ok || frame_err) begin
      if (exp_res.size() == 0) begin
        check("unexp_pulse", {frame_ok, frame_err}, 0);
      end else begin
        r = exp_res.pop_front();
        check("frame_ok", frame_ok, r.ok);
        check("frame_err", frame_err, !r.ok);
        check("err_code", err_code, r.code);
        if (r.code == 2'b11) check("timeout_latency", cyc - last_pop_cyc, TO);
      end
    end
  endtask

  // One clock: sample mid-low-phase, let the DUT pop at the edge, then retire the popped byte.
  task automatic tick();
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    monitor();
    pop_pending = rd_uart;
    @(posedge clk);
    cyc++;
    #1;
    if (pop_pending) begin
      void'(fifo.pop_front());
      last_pop_cyc = cyc;
    end
    refresh();
    @(negedge clk);
  endtask

  function automatic logic [7:0] model_sum();
    logic [7:0] s;
    s = 8'(pl.size());
    foreach (pl[i]) s = s + pl[i];
    return s;
  endfunction

  task automatic send_frame(input logic [7:0] csum);
    res_t r;
    push(8'h7E);
    push(8'(pl.size()));
    foreach (pl[i]) begin
      push(pl[i]);
      exp_beats.push_back('{data: pl[i], last: (i == pl.size() - 1)});
    end
    push(csum);
    r.ok   = (csum == model_sum());
    r.code = r.ok ? 2'b00 : 2'b10;
    exp_res.push_back(r);
  endtask

  task automatic send_bad_len(input logic [7:0] len);
    push(8'h7E);
    push(len);
    exp_res.push_back('{ok: 1'b0, code: 2'b01});
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_beats.size() != 0 || exp_res.size() != 0 || fifo.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("wait_expired", 1, 0);
    repeat (3) tick();
  endtask

  task automatic wait_beats(input int left, input int budget);
    int n = 0;
    while (exp_beats.size() > left && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("beat_wait_expired", 1, 0);
  endtask

  initial begin
    logic [7:0] cs;
    rst       = 1'b1;
    out_ready = 1'b1;
    refresh();

    // Reset: a waiting byte must not be popped and the outputs stay quiet.
    push(8'h7E);
    repeat (3) begin
      tick();
      check("rst_rd_uart", rd_uart, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
    end
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    fifo.delete();
    refresh();
    rst = 1'b0;
    tick();

    // Good frame 7E 03 11 22 33 69.
    pl = {8'h11, 8'h22, 8'h33};
    send_frame(8'h69);
    wait_done(100);
    check("good_err_code", err_code, 2'b00);

    // Bad checksum 7E 02 AA 55 00 (expected 01); err_code holds afterwards.
    pl = {8'hAA, 8'h55};
    send_frame(8'h00);
    wait_done(100);
    check("csum_err_code_held", err_code, 2'b10);

    // Reset mid-frame: no result pulse, error code cleared.
    pl = {8'h01, 8'h02};
    push(8'h7E);
    push(8'h05);
    foreach (pl[i]) begin
      push(pl[i]);
      exp_beats.push_back('{data: pl[i], last: 1'b0});
    end
    wait_beats(0, 50);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("midrst_err_code", err_code, 2'b00);
    check("midrst_drop_cnt", drop_cnt, 0);

    // Zero and oversize lengths, then a good frame.
    send_bad_len(8'h00);
    send_bad_len(8'(ML + 1));
    wait_done(100);
    check("len_err_code_held", err_code, 2'b01);
    pl = {8'h11, 8'h22, 8'h33};
    send_frame(8'h69);
    wait_done(100);

    // Two junk bytes while hunting, then a good frame.
    push(8'h00);
    push(8'hFF);
    send_frame(8'h69);
    wait_done(100);
    check("drop_cnt", drop_cnt, 8'd2);

    // Timeout after 7E 02 AA, then a good frame proves the parser is hunting again.
    push(8'h7E);
    push(8'h02);
    push(8'hAA);
    exp_beats.push_back('{data: 8'hAA, last: 1'b0});
    exp_res.push_back('{ok: 1'b0, code: 2'b11});
    wait_done(4 * TO);
    check("timeout_err_code_held", err_code, 2'b11);
    pl = {8'h7E, 8'h42};
    send_frame(model_sum());
    wait_done(100);

    // Downstream stall longer than the timeout with data waiting.
    pl = {8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(model_sum());
    wait_beats(2, 50);
    out_ready = 1'b0;
    repeat (100) begin
      tick();
      check("stall_rd_uart", rd_uart, 0);
    end
    check("stall_no_loss", fifo.size(), 3);
    out_ready = 1'b1;
    wait_done(100);

    // Random frames with random backpressure; about a third carry a corrupted checksum.
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      pl.delete();
      for (int i = 0; i < int'($urandom_range(1, ML)); i++) pl.push_back(8'($urandom_range(0, 255)));
      cs = model_sum();
      if ($urandom_range(0, 2) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      send_frame(cs);
      wait_done(400);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    check("final_drop_cnt", drop_cnt, 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
